// File: rtl/updi_cs_poller_pkg.sv
// Shared UPDI types: instruction opcodes, poller error codes, poller FSM states.
package updi_cs_poller_pkg;

  // Upper opcode nibble of the UPDI instruction set
  typedef enum logic [3:0] {
    UPDI_LDS    = 4'h0,
    UPDI_LD     = 4'h2,
    UPDI_STS    = 4'h4,
    UPDI_ST     = 4'h6,
    UPDI_LDCS   = 4'h8,
    UPDI_REPEAT = 4'ha,
    UPDI_STCS   = 4'hc,
    UPDI_KEY    = 4'he
  } updi_instruction;

  // Result code of a poll run
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_ABORTED  = 2'd3
  } poll_err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RX,
    ST_POP,
    ST_CHECK,
    ST_GAP,
    ST_FINISH
  } poll_state_t;

  // True when every bit selected by m has the value required by e
  function automatic logic masked_match(input logic [7:0] s, input logic [7:0] m,
                                        input logic [7:0] e);
    return ((s ^ e) & m) == 8'h00;
  endfunction

endpackage

// File: rtl/updi_cs_poller_delay.sv
// Retriggerable delay: after a start pulse, done is high in the N_CLKS-th cycle.
module updi_cs_poller_delay #(
  parameter int N_CLKS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CW = (N_CLKS < 2) ? 1 : $clog2(N_CLKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  // Load on start, count down to zero, then stop
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = CW'(N_CLKS - 1);
    end else if (run_q) begin
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/updi_cs_poller.sv
// Repeatedly reads a UPDI control/status register with LDCS until the masked
// value matches, the attempt budget is used up, a response times out, or abort.
module updi_cs_poller
  import updi_cs_poller_pkg::*;
#(
  parameter int MAX_POLLS          = 16,
  parameter int POLL_INTERVAL_CLKS = 100,
  parameter int TIMEOUT_CLKS       = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [3:0]      cs_addr_in,
  input  logic [7:0]      mask,
  input  logic [7:0]      expect_val,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output poll_err_t       err,
  output logic [7:0]      status_out,
  output logic [7:0]      poll_count,
  output logic            instr_converter_en,
  output updi_instruction instruction,
  output logic [3:0]      cs_addr,
  output logic            tx_start,
  output logic            rx_start,
  output logic [7:0]      rx_n_bytes,
  input  logic            tx_ready,
  input  logic            ack_error,
  input  logic [7:0]      fifo_data,
  output logic            fifo_rd_en,
  input  logic            fifo_empty
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  poll_state_t   state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [7:0]    mask_q, mask_d;
  logic [7:0]    exp_q, exp_d;
  logic          pass_q, pass_d;
  poll_err_t     err_q, err_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          issue;
  logic          gap_start;
  logic          gap_done;

  updi_cs_poller_delay #(.N_CLKS(POLL_INTERVAL_CLKS)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .start (gap_start),
    .done  (gap_done)
  );

  // Next-state, result updates and single-cycle interface strobes
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    exp_d      = exp_q;
    pass_d     = pass_q;
    err_d      = err_q;
    status_d   = status_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    issue      = 1'b0;
    gap_start  = 1'b0;
    fifo_rd_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = cs_addr_in;
          mask_d  = mask;
          exp_d   = expect_val;
          count_d = 8'd0;
          pass_d  = 1'b0;
          err_d   = ERR_NONE;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          err_d   = ERR_ABORTED;
          state_d = ST_FINISH;
        end else if (tx_ready) begin
          issue   = 1'b1;
          count_d = count_q + 8'd1;
          tmo_d   = '0;
          state_d = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        if (abort) begin
          err_d   = ERR_ABORTED;
          state_d = ST_FINISH;
        end else if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_POP;
        end else if (ack_error || (tmo_q == TMO_LAST)) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_FINISH;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_POP: begin
        // The byte was already popped, so keep it even if the run is aborted
        status_d = fifo_data;
        if (abort) begin
          err_d   = ERR_ABORTED;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          err_d   = ERR_ABORTED;
          state_d = ST_FINISH;
        end else if (masked_match(status_q, mask_q, exp_q)) begin
          pass_d  = 1'b1;
          state_d = ST_FINISH;
        end else if (count_q == 8'(MAX_POLLS)) begin
          err_d   = ERR_MISMATCH;
          state_d = ST_FINISH;
        end else begin
          gap_start = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (abort) begin
          err_d   = ERR_ABORTED;
          state_d = ST_FINISH;
        end else if (gap_done) begin
          state_d = ST_ISSUE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      mask_q   <= '0;
      exp_q    <= '0;
      pass_q   <= 1'b0;
      err_q    <= ERR_NONE;
      status_q <= '0;
      count_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      exp_q    <= exp_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      status_q <= status_d;
      count_q  <= count_d;
      tmo_q    <= tmo_d;
    end
  end

  assign busy               = (state_q != ST_IDLE);
  assign done               = (state_q == ST_FINISH);
  assign pass               = pass_q;
  assign err                = err_q;
  assign status_out         = status_q;
  assign poll_count         = count_q;
  assign instruction        = UPDI_LDCS;
  assign instr_converter_en = issue;
  assign tx_start           = issue;
  assign rx_start           = issue;
  assign cs_addr            = issue ? addr_q : 4'h0;
  assign rx_n_bytes         = issue ? 8'd1 : 8'd0;

endmodule

// File: tb/tb_updi_cs_poller.sv
// Bench for updi_cs_poller: a scripted responder feeds one status byte (or none)
// per LDCS request and a run-level reference model predicts each outcome.
module tb_updi_cs_poller;
  import updi_cs_poller_pkg::*;

  localparam int MAXP = 3;
  localparam int GAPC = 5;
  localparam int TMO  = 40;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [3:0]      cs_addr_in = '0;
  logic [7:0]      mask = '0;
  logic [7:0]      expect_val = '0;
  logic            busy, done, pass;
  poll_err_t       err;
  logic [7:0]      status_out, poll_count;
  logic            instr_converter_en;
  updi_instruction instruction;
  logic [3:0]      cs_addr;
  logic            tx_start, rx_start;
  logic [7:0]      rx_n_bytes;
  logic            tx_ready;
  logic            ack_error = 1'b0;
  logic [7:0]      fifo_data;
  logic            fifo_rd_en;
  logic            fifo_empty;

  updi_cs_poller #(
    .MAX_POLLS(MAXP), .POLL_INTERVAL_CLKS(GAPC), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cs_addr_in(cs_addr_in),
    .mask(mask), .expect_val(expect_val), .busy(busy), .done(done), .pass(pass),
    .err(err), .status_out(status_out), .poll_count(poll_count),
    .instr_converter_en(instr_converter_en), .instruction(instruction),
    .cs_addr(cs_addr), .tx_start(tx_start), .rx_start(rx_start),
    .rx_n_bytes(rx_n_bytes), .tx_ready(tx_ready), .ack_error(ack_error),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  // Scripted responses, indexed by absolute request number (lat < 0: no reply)
  logic [7:0] resp_b [0:1023];
  int         resp_l [0:1023];

  // Responder / monitor state
  int         cyc = 0;
  int         tx_cnt = 0;
  int         rd_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         viol = 0;
  int         cd = -1;
  logic       have_byte = 1'b0;
  logic [7:0] byte_val = '0;
  logic       prev_done = 1'b0;
  logic       rdy_rand = 1'b0;
  int         tx_cyc  [0:1023];
  logic [3:0] tx_addr [0:1023];
  logic       tx_good [0:1023];

  assign fifo_empty = !have_byte;

  always @(posedge clk) cyc <= cyc + 1;

  // Link/FIFO responder and protocol monitor
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      have_byte <= 1'b0;
      cd        <= -1;
      tx_ready  <= 1'b1;
      prev_done <= 1'b0;
    end else begin
      tx_ready <= rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      viol <= viol + int'(fifo_rd_en && !have_byte)
                   + int'(!tx_start && (instr_converter_en || rx_start || rx_n_bytes != 8'd0))
                   + int'(done && prev_done);
      if (fifo_rd_en) begin
        fifo_data <= byte_val;
        have_byte <= 1'b0;
        rd_cnt    <= rd_cnt + 1;
      end
      if (tx_start) begin
        tx_cyc[tx_cnt]  <= cyc;
        tx_addr[tx_cnt] <= cs_addr;
        tx_good[tx_cnt] <= instr_converter_en && rx_start && (rx_n_bytes == 8'd1) &&
                           (instruction == UPDI_LDCS);
        cd       <= resp_l[tx_cnt];
        byte_val <= resp_b[tx_cnt];
        tx_cnt   <= tx_cnt + 1;
      end else if (cd == 0) begin
        have_byte <= 1'b1;
        cd        <= -1;
      end else if (cd > 0) begin
        cd <= cd - 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      prev_done <= done;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] model_status = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic set_resp(input int i, input logic [7:0] b, input int l);
    resp_b[tx_cnt + i] = b;
    resp_l[tx_cnt + i] = l;
  endtask

  task automatic clear_resp();
    for (int i = 0; i < MAXP + 2; i++) set_resp(i, 8'h00, -1);
  endtask

  task automatic do_start(input logic [3:0] a, input logic [7:0] m, input logic [7:0] e);
    @(posedge clk); #1;
    start = 1'b1; cs_addr_in = a; mask = m; expect_val = e;
    @(posedge clk); #1;
    start = 1'b0;
    cs_addr_in = 4'($urandom); mask = 8'($urandom); expect_val = 8'($urandom);
  endtask

  task automatic wait_done(input int d0, input string tag);
    int g = 0;
    while (done_cnt == d0 && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    if (done_cnt == d0) check({tag, "_done_bound"}, 0, 1);
  endtask

  task automatic wait_tx(input int n, input string tag);
    int g = 0;
    while (tx_cnt < n && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    if (tx_cnt < n) check({tx_cnt < n ? tag : tag, "_tx_bound"}, 0, 1);
  endtask

  // Reference: walk the scripted replies attempt by attempt
  task automatic model_run(input int base, input logic [7:0] m, input logic [7:0] e,
                           output logic ep, output logic [1:0] ee, output int np);
    ep = 1'b0; ee = 2'd0; np = 0;
    for (int i = 0; i < MAXP; i++) begin
      np = i + 1;
      if (resp_l[base + i] < 0) begin
        ee = 2'd2;
        break;
      end
      model_status = resp_b[base + i];
      if ((model_status & m) == (e & m)) begin
        ep = 1'b1;
        break;
      end
      if (i == MAXP - 1) ee = 2'd1;
    end
  endtask

  task automatic std_run(input logic [3:0] a, input logic [7:0] m, input logic [7:0] e,
                         input string tag);
    int base, d0, np;
    logic ep;
    logic [1:0] ee;
    base = tx_cnt;
    d0   = done_cnt;
    do_start(a, m, e);
    wait_done(d0, tag);
    model_run(base, m, e, ep, ee, np);
    $display("run %s addr=%0h mask=%02h exp=%02h -> pass=%0b err=%0d status=%02h polls=%0d",
             tag, a, m, e, pass, err, status_out, poll_count);
    check({tag, "_pass"}, 32'(pass), 32'(ep));
    check({tag, "_err"}, 32'(err), 32'(ee));
    check({tag, "_status"}, 32'(status_out), 32'(model_status));
    check({tag, "_polls"}, 32'(poll_count), 32'(np));
    check({tag, "_ntx"}, 32'(tx_cnt - base), 32'(np));
    for (int k = 0; k < np; k++) begin
      check({tag, "_addr"}, 32'(tx_addr[base + k]), 32'(a));
      check({tag, "_txfields"}, 32'(tx_good[base + k]), 1);
      if (k > 0) check({tag, "_gap"}, 32'(tx_cyc[base + k] - tx_cyc[base + k - 1] >= GAPC + 4), 1);
    end
  endtask

  initial begin
    int base, d0, r0;
    logic [7:0] m, e, b;

    for (int i = 0; i < 1024; i++) begin
      resp_b[i] = 8'h00;
      resp_l[i] = -1;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_err", 32'(err), 32'(ERR_NONE));
    check("rst_status", 32'(status_out), 0);
    check("rst_polls", 32'(poll_count), 0);
    check("rst_strobes", 32'({tx_start, rx_start, instr_converter_en, fifo_rd_en}), 0);
    check("rst_instr", 32'(instruction), 32'(UPDI_LDCS));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // First byte matches the masked bit
    clear_resp();
    set_resp(0, 8'h08, 2);
    std_run(4'h3, 8'h08, 8'h08, "first_match");

    // Budget exhausted with all-zero replies
    clear_resp();
    for (int i = 0; i < MAXP; i++) set_resp(i, 8'h00, $urandom_range(0, 4));
    std_run(4'h7, 8'h08, 8'h08, "mismatch");

    // No reply at all: timeout after exactly TMO cycles of waiting
    clear_resp();
    base = tx_cnt;
    std_run(4'h2, 8'h01, 8'h01, "timeout");
    check("timeout_latency", 32'(done_cyc - tx_cyc[base]), 32'(TMO + 1));

    // Zero mask passes on any byte
    clear_resp();
    set_resp(0, 8'($urandom), 1);
    std_run(4'h1, 8'h00, 8'($urandom), "mask_zero");

    // Link acknowledge error while waiting
    clear_resp();
    base = tx_cnt; d0 = done_cnt;
    do_start(4'h4, 8'hff, 8'h00);
    wait_tx(base + 1, "ackerr");
    repeat (3) @(posedge clk);
    #1;
    ack_error = 1'b1;
    @(posedge clk); #1;
    ack_error = 1'b0;
    wait_done(d0, "ackerr");
    $display("run ackerr -> pass=%0b err=%0d polls=%0d", pass, err, poll_count);
    check("ackerr_err", 32'(err), 32'(ERR_TIMEOUT));
    check("ackerr_pass", 32'(pass), 0);
    check("ackerr_early", 32'(done_cyc - tx_cyc[base] < TMO), 1);

    // Abort during the gap after the second attempt
    clear_resp();
    for (int i = 0; i < MAXP; i++) set_resp(i, 8'h00, 1);
    base = tx_cnt; d0 = done_cnt; r0 = rd_cnt;
    do_start(4'h6, 8'hff, 8'hff);
    begin
      int g = 0;
      while (rd_cnt < r0 + 2 && g < 3000) begin
        @(posedge clk); #1;
        g++;
      end
      if (rd_cnt < r0 + 2) check("abort_rd_bound", 0, 1);
    end
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(d0, "abort");
    repeat (20) @(posedge clk);
    #1;
    model_status = 8'h00;
    $display("run abort -> err=%0d polls=%0d tx=%0d", err, poll_count, tx_cnt - base);
    check("abort_err", 32'(err), 32'(ERR_ABORTED));
    check("abort_ntx", 32'(tx_cnt - base), 2);
    check("abort_polls", 32'(poll_count), 2);
    check("abort_pass", 32'(pass), 0);

    // Start while busy is ignored
    clear_resp();
    set_resp(0, 8'h5a, 8);
    base = tx_cnt; d0 = done_cnt;
    do_start(4'h5, 8'hff, 8'h5a);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; cs_addr_in = 4'h9; mask = 8'hff; expect_val = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, "busy_start");
    model_status = 8'h5a;
    $display("run busy_start -> pass=%0b polls=%0d addr=%0h", pass, poll_count, tx_addr[base]);
    check("busy_start_pass", 32'(pass), 1);
    check("busy_start_addr", 32'(tx_addr[base]), 32'h5);
    check("busy_start_ntx", 32'(tx_cnt - base), 1);

    // Reset in the middle of WAIT_RX, then a clean run
    clear_resp();
    base = tx_cnt;
    do_start(4'ha, 8'hff, 8'hff);
    wait_tx(base + 1, "midrst");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_polls", 32'(poll_count), 0);
    check("midrst_status", 32'(status_out), 0);
    check("midrst_strobes", 32'({tx_start, rx_start, instr_converter_en, fifo_rd_en, done}), 0);
    rst = 1'b1;
    model_status = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_idle", 32'(busy), 0);
    clear_resp();
    set_resp(0, 8'h81, 0);
    std_run(4'hb, 8'h80, 8'h80, "after_rst");

    // Randomized runs with a stalling transmitter
    rdy_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      m = 8'($urandom);
      e = 8'($urandom);
      clear_resp();
      for (int i = 0; i < MAXP; i++) begin
        b = 8'($urandom);
        if ($urandom_range(0, 2) == 0) b = (e & m) | (b & ~m);
        set_resp(i, b, ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 6));
      end
      std_run(4'($urandom), m, e, $sformatf("rand%0d", n));
    end
    rdy_rand = 1'b0;

    check("protocol_violations", 32'(viol), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/updi_cs_poller.md
UPDI_CS_POLLER -- requirements
Module: updi_cs_poller

Interface
REQ-001 Parameter MAX_POLLS, default 16: maximum LDCS read attempts per run, range 1..255.
REQ-002 Parameter POLL_INTERVAL_CLKS, default 100: idle gap between attempts, in clk cycles.
REQ-003 Parameter TIMEOUT_CLKS, default 4096: maximum wait for a response byte, in clk cycles.
REQ-004 Port clk, input, 1: single clock; every flop is clocked on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port start, input, 1: accepted only in IDLE; latches cs_addr_in, mask, expect.
REQ-007 Port abort, input, 1: ends an active run with error ABORTED.
REQ-008 Port cs_addr_in, input, 4: UPDI control/status register address.
REQ-009 Port mask / expect, input, 8 each: bits compared and their required values.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port done, output, 1: one-cycle pulse when a run ends.
REQ-012 Port pass, output, 1: sticky result; high when the masked status matched.
REQ-013 Port err, output, 2 (poll_err_t): NONE=0, MISMATCH=1, TIMEOUT=2, ABORTED=3; sticky.
REQ-014 Port status_out, output, 8: last status byte received; sticky.
REQ-015 Port poll_count, output, 8: attempts issued in the current or last run.
REQ-016 Ports to updi_interface: instr_converter_en, instruction (updi_instruction), cs_addr[3:0], tx_start, rx_start, rx_n_bytes, outputs; tx_ready, ack_error, inputs.
REQ-017 Ports to the RX output FIFO: fifo_data[7:0] in, fifo_rd_en out, fifo_empty in; fifo_data is valid the cycle after fifo_rd_en.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT_RX, POP, CHECK, GAP, FINISH.
REQ-019 IDLE -> ISSUE on start; in that cycle latch inputs, clear poll_count, and set pass=0, err=NONE.
REQ-020 ISSUE: hold until tx_ready=1; in that cycle, for one cycle only, assert instr_converter_en, instruction=UPDI_LDCS, cs_addr=latched address, tx_start, rx_start, rx_n_bytes=1; increment poll_count; go to WAIT_RX.
REQ-021 WAIT_RX: a timeout counter clears on entry and increments each cycle; when fifo_empty=0, assert fifo_rd_en combinationally and go to POP.
REQ-022 WAIT_RX: when the timeout counter reaches TIMEOUT_CLKS-1 with fifo_empty=1 -> FINISH, err=TIMEOUT.
REQ-023 POP: capture fifo_data into status_out; go to CHECK.
REQ-024 CHECK: if (status_out & mask) == (expect & mask) -> FINISH, pass=1.
REQ-025 CHECK: on mismatch with poll_count == MAX_POLLS -> FINISH, err=MISMATCH; otherwise -> GAP.
REQ-026 GAP: wait exactly POLL_INTERVAL_CLKS cycles, then -> ISSUE.
REQ-027 FINISH: pulse done for one cycle, then -> IDLE; results hold until the next accepted start.
REQ-028 ack_error=1 in WAIT_RX -> FINISH, err=TIMEOUT.
REQ-029 abort in any non-IDLE, non-FINISH state -> FINISH, err=ABORTED; abort takes priority over a same-cycle match or timeout.
REQ-030 start is ignored while busy=1.
REQ-031 mask=0x00 passes on the first received byte.
REQ-032 All interface strobes SHALL be low outside the cycles named above; fifo_rd_en never asserts when fifo_empty=1.

Reset
REQ-033 While rst=0, the block SHALL hold state=IDLE with every output and counter zero (err=NONE, instruction=UPDI_LDCS).
REQ-034 A reset during a run SHALL leave no in-flight strobes when it releases; the block then sits in IDLE.

Structure
REQ-035 poll_err_t SHALL be defined in the shared UPDI package beside updi_instruction.
REQ-036 The GAP wait SHALL use one existing delay instance with N_CLKS=POLL_INTERVAL_CLKS.
REQ-037 The timeout counter SHALL be local, sized $clog2(TIMEOUT_CLKS+1).

Verification
REQ-038 mask=0x08, expect=0x08, first byte 0x08 -> poll_count=1, pass=1, err=NONE, done pulse.
REQ-039 MAX_POLLS=3, bytes 0x00,0x00,0x00 -> three LDCS issues spaced at least POLL_INTERVAL_CLKS apart, err=MISMATCH, status_out=0x00.
REQ-040 No byte for TIMEOUT_CLKS cycles -> err=TIMEOUT, pass=0, exactly one tx_start seen.
REQ-041 abort in GAP of poll 2 -> err=ABORTED in FINISH, no third tx_start.
REQ-042 rst=0 during WAIT_RX, then start again -> clean run with poll_count starting at 1; start while busy=1 -> ignored.
